// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch-side initiator for a synchronous instruction memory with a
//   one-cycle registered read. Owns the PC, pairs each returned word with
//   the address it came from, and handles decode stalls and redirects.
//
//   Optional feature macro: FETCH_HALT_EN
//     defined   - fetch stops after delivering word DEPTH-1 and sits in
//                 HALTED until a redirect or reset.
//     undefined - PC wraps from DEPTH-1 to 0 and fetch never stops.
module instr_fetch_unit #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INSTR_WIDTH = 32,
   parameter int DEPTH       = 32,
   parameter int RESET_PC    = 0
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   input  logic                   Stall,
   input  logic                   Redirect,
   input  logic [ADDR_WIDTH-1:0]  RedirectTarget,
   output logic [ADDR_WIDTH-1:0]  Address,
   input  logic [INSTR_WIDTH-1:0] ReadData,
   output logic [INSTR_WIDTH-1:0] Instr,
   output logic [ADDR_WIDTH-1:0]  InstrPC,
   output logic                   InstrValid,
   output logic                   Halted
);

   // Only the low log2(DEPTH) bits of any address are significant.
   localparam logic [ADDR_WIDTH-1:0] IDX_MASK   = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_PC    = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC) & IDX_MASK;
   localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
   logic [ADDR_WIDTH-1:0]   rsp_pc_reg, rsp_pc_next;
   logic                    rsp_valid_reg, rsp_valid_next;

   logic [ADDR_WIDTH-1:0]   target_idx;
   logic [ADDR_WIDTH-1:0]   target_inc;
   logic [ADDR_WIDTH-1:0]   pc_inc;
   logic                    halt_hit;

   assign target_idx = RedirectTarget & IDX_MASK;
   assign target_inc = (target_idx + ONE) & IDX_MASK;
   assign pc_inc     = (pc_reg + ONE) & IDX_MASK;

   // The fetch of the last slot is what parks the unit when halting is enabled.
`ifdef FETCH_HALT_EN
   assign halt_hit = (pc_reg == LAST_PC);
`else
   assign halt_hit = 1'b0;
`endif

   // State register and fetch-pipeline registers; async reset discards any word in flight.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg     <= RUN;
         pc_reg        <= RESET_ADDR;
         rsp_pc_reg    <= '0;
         rsp_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         rsp_pc_reg    <= rsp_pc_next;
         rsp_valid_reg <= rsp_valid_next;
      end
   end

   // Next-state: redirect beats stall, stall freezes everything, otherwise advance.
   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      rsp_pc_next    = rsp_pc_reg;
      rsp_valid_next = rsp_valid_reg;
      if (Redirect) begin
         // The word currently on ReadData belongs to the wrong path and is dropped.
         state_next     = RUN;
         rsp_pc_next    = target_idx;
         rsp_valid_next = 1'b1;
         pc_next        = target_inc;
      end else if (Stall) begin
         // Hold: Address re-reads rsp_pc so ReadData stays put.
      end else if (state_reg == HALTED) begin
         rsp_valid_next = 1'b0;
      end else begin
         rsp_pc_next    = pc_reg;
         rsp_valid_next = 1'b1;
         if (halt_hit) begin
            state_next = HALTED;
         end else begin
            pc_next = pc_inc;
         end
      end
   end

   // Outputs: memory address by priority, and the word presented to decode.
   always_comb begin
      if (Redirect) begin
         Address = target_idx;
      end else if (Stall || (state_reg == HALTED)) begin
         Address = rsp_pc_reg;
      end else begin
         Address = pc_reg;
      end
      Instr      = ReadData;
      InstrPC    = rsp_pc_reg;
      InstrValid = rsp_valid_reg & ~Redirect;
`ifdef FETCH_HALT_EN
      Halted     = (state_reg == HALTED);
`else
      Halted     = 1'b0;
`endif
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a registered-read instruction memory, a
// stream-level reference model of which word decode should see, a per-cycle
// compare process, and directed scenarios with literal expectations.
// Honours FETCH_HALT_EN in the same way as the design.
module tb_instr_fetch_unit;

   localparam int AW    = 32;
   localparam int IW    = 32;
   localparam int DEPTH = 32;
   localparam int RPC   = 0;

   logic          Clk = 1'b0;
   logic          Rst_n = 1'b1;
   logic          Stall = 1'b0;
   logic          Redirect = 1'b0;
   logic [AW-1:0] RedirectTarget = '0;
   logic [AW-1:0] Address;
   logic [IW-1:0] ReadData = '0;
   logic [IW-1:0] Instr;
   logic [AW-1:0] InstrPC;
   logic          InstrValid;
   logic          Halted;

   int checks   = 0;
   int failures = 0;

   logic [IW-1:0] mem [DEPTH];

   instr_fetch_unit #(
      .ADDR_WIDTH (AW),
      .INSTR_WIDTH(IW),
      .DEPTH      (DEPTH),
      .RESET_PC   (RPC)
   ) dut (
      .Clk           (Clk),
      .Rst_n         (Rst_n),
      .Stall         (Stall),
      .Redirect      (Redirect),
      .RedirectTarget(RedirectTarget),
      .Address       (Address),
      .ReadData      (ReadData),
      .Instr         (Instr),
      .InstrPC       (InstrPC),
      .InstrValid    (InstrValid),
      .Halted        (Halted)
   );

   always #5 Clk = ~Clk;

   // Synchronous memory: one-cycle registered read of the word at Address.
   always @(posedge Clk) ReadData <= mem[Address[4:0]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: which word is on the decode port, which comes next,
   // and whether fetch has parked.
   int m_cur;
   int m_next;
   bit m_live;
   bit m_halt;

   always @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         m_cur  = 0;
         m_next = RPC;
         m_live = 0;
         m_halt = 0;
      end else if (Redirect) begin
         m_cur  = int'(RedirectTarget % DEPTH);
         m_next = (m_cur + 1) % DEPTH;
         m_live = 1;
         m_halt = 0;
      end else if (Stall) begin
         // nothing moves
      end else if (m_halt) begin
         m_live = 0;
      end else begin
         m_cur  = m_next;
         m_live = 1;
`ifdef FETCH_HALT_EN
         if (m_next == DEPTH - 1) m_halt = 1;
         else m_next = (m_next + 1) % DEPTH;
`else
         m_next = (m_next + 1) % DEPTH;
`endif
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge Clk) begin
      logic [31:0] exp_addr;
      bit          exp_valid;
      exp_valid = m_live && !Redirect;
      if (Redirect)               exp_addr = RedirectTarget % DEPTH;
      else if (Stall || m_halt)   exp_addr = 32'(m_cur);
      else                        exp_addr = 32'(m_next);
      chk("cyc_valid", {31'd0, InstrValid}, {31'd0, exp_valid});
      chk("cyc_addr", Address, exp_addr);
      chk("cyc_halted", {31'd0, Halted}, {31'd0, m_halt});
      if (exp_valid) begin
         chk("cyc_pc", InstrPC, 32'(m_cur));
         chk("cyc_instr", Instr, mem[m_cur]);
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic look();
      @(negedge Clk);
      #1;
   endtask

   task automatic run_until(input int want);
      bit hit = 0;
      for (int i = 0; i < 64 && !hit; i++) begin
         tick();
         look();
         if (InstrValid && InstrPC == 32'(want)) hit = 1;
      end
      chk($sformatf("reach_pc_%0d", want), {31'd0, hit}, 32'd1);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
      mem[0] = 32'h2001_0001;
      mem[1] = 32'h2014_DEAD;

      // Reset
      #1 Rst_n = 1'b0;
      look();
      chk("rst_valid", {31'd0, InstrValid}, 32'd0);
      chk("rst_addr", Address, 32'(RPC));
      chk("rst_halted", {31'd0, Halted}, 32'd0);
      chk("rst_pc", InstrPC, 32'd0);
      tick();
      Rst_n = 1'b1;
      look();
      chk("rel_valid", {31'd0, InstrValid}, 32'd0);
      chk("rel_addr", Address, 32'(RPC));

      // First two words after release
      tick(); look();
      chk("w0_valid", {31'd0, InstrValid}, 32'd1);
      chk("w0_pc", InstrPC, 32'd0);
      chk("w0_instr", Instr, 32'h2001_0001);
      tick(); look();
      chk("w1_pc", InstrPC, 32'd1);
      chk("w1_instr", Instr, 32'h2014_DEAD);

      // Three-cycle stall on word 5
      run_until(4);
      tick(); Stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         look();
         chk("stall_pc", InstrPC, 32'd5);
         chk("stall_valid", {31'd0, InstrValid}, 32'd1);
         chk("stall_addr", Address, 32'd5);
         chk("stall_instr", Instr, mem[5]);
         if (k < 2) tick();
      end
      tick(); Stall = 1'b0;
      look();
      chk("unstall_pc", InstrPC, 32'd5);
      chk("unstall_addr", Address, 32'd6);
      tick(); look();
      chk("after_stall_pc", InstrPC, 32'd6);

      // Redirect to 16 while word 11 is on the port
      run_until(10);
      tick(); Redirect = 1'b1; RedirectTarget = 32'd16;
      look();
      chk("redir_pc_on_port", InstrPC, 32'd11);
      chk("redir_squash", {31'd0, InstrValid}, 32'd0);
      chk("redir_addr", Address, 32'd16);
      tick(); Redirect = 1'b0;
      look();
      chk("redir_tgt_pc", InstrPC, 32'd16);
      chk("redir_tgt_valid", {31'd0, InstrValid}, 32'd1);

      // Redirect together with stall at word 17; target has upper bits set
      tick(); Redirect = 1'b1; Stall = 1'b1; RedirectTarget = 32'h0000_0030;
      look();
      chk("rs_pc_on_port", InstrPC, 32'd17);
      chk("rs_squash", {31'd0, InstrValid}, 32'd0);
      chk("rs_addr_mod", Address, 32'd16);
      tick(); Redirect = 1'b0; Stall = 1'b0;
      look();
      chk("rs_tgt_pc", InstrPC, 32'd16);
      chk("rs_tgt_valid", {31'd0, InstrValid}, 32'd1);

      // Run to the last slot
      run_until(30);
      tick(); look();
      chk("last_pc", InstrPC, 32'd31);
      chk("last_valid", {31'd0, InstrValid}, 32'd1);
`ifdef FETCH_HALT_EN
      for (int k = 0; k < 3; k++) begin
         tick(); look();
         chk("halt_valid", {31'd0, InstrValid}, 32'd0);
         chk("halt_flag", {31'd0, Halted}, 32'd1);
         chk("halt_addr", Address, 32'd31);
      end
      tick(); Redirect = 1'b1; RedirectTarget = 32'd0;
      look();
      tick(); Redirect = 1'b0;
      look();
      chk("unhalt_pc", InstrPC, 32'd0);
      chk("unhalt_valid", {31'd0, InstrValid}, 32'd1);
      chk("unhalt_flag", {31'd0, Halted}, 32'd0);
`else
      tick(); look();
      chk("wrap_pc", InstrPC, 32'd0);
      chk("wrap_valid", {31'd0, InstrValid}, 32'd1);
      chk("wrap_halted", {31'd0, Halted}, 32'd0);
`endif

      // Asynchronous reset mid-stream at word 9
      run_until(8);
      tick(); look();
      chk("pre_rst_pc", InstrPC, 32'd9);
      Rst_n = 1'b0;
      #1;
      chk("async_rst_valid", {31'd0, InstrValid}, 32'd0);
      chk("async_rst_addr", Address, 32'(RPC));
      tick(); tick();
      Rst_n = 1'b1;
      look();
      chk("rel2_valid", {31'd0, InstrValid}, 32'd0);
      tick(); look();
      chk("refetch_pc", InstrPC, 32'(RPC));
      chk("refetch_valid", {31'd0, InstrValid}, 32'd1);
      chk("refetch_instr", Instr, 32'h2001_0001);
      tick(); look();
      chk("refetch_next_pc", InstrPC, 32'd1);

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
